alu_wb_seq: RTL and testbench
=============================

Name: alu_wb_seq

Overview:
- Write-back sequencer directly downstream of the 32-bit ALU in the multicycle ARM datapath.
- Captures the ALU low/high results and NZCV flags into architectural registers: ALUOut and the flag register.
- Turns each ALU result into register-file write beats: one beat for normal ops, two sequential beats (RdLo then RdHi) for UMULL/SMULL.
- Computes 64-bit N/Z for long multiplies, which the ALU's 32-bit flag logic cannot.

Parameters:
- DATA_W, 32, datapath width; must equal the ALU width.
- ADDR_W, 4, register-file address width (R0..R15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result valid, issued by the control FSM in its ALU/execute state.
- in_ready  output  1  sequencer can accept a result; high only in IDLE.
- Result  input  DATA_W  ALU primary result; product[63:32] for long ops.
- Result2  input  DATA_W  ALU secondary result; product[31:0] for long ops; ignored otherwise.
- ALUFlags  input  4  {N,Z,C,V} from the ALU.
- long_op  input  1  high for UMULL/SMULL (ALUControl 110/111).
- reg_write  input  1  perform a register-file write for this op.
- FlagWrite  input  2  [1] updates N,Z; [0] updates C,V.
- rd_lo  input  ADDR_W  destination for normal ops, or RdLo for long ops.
- rd_hi  input  ADDR_W  RdHi for long ops.
- wb_ready  input  1  register-file write port free this cycle.
- ALUOut  output  DATA_W  registered ALU result; for long ops holds the low word.
- Flags  output  4  architectural NZCV register.
- WE3  output  1  register-file write enable.
- A3  output  ADDR_W  register-file write address.
- WD3  output  DATA_W  register-file write data.
- done  output  1  one-cycle pulse when the final write beat completes, or on the capture cycle if reg_write=0.

Behaviour:
- Reset (async, reset=0) values:
  - ALUOut=0, Flags=0, WE3=0, A3=0, WD3=0, done=0, in_ready=0 while asserted.
  - State=IDLE.
  - Capture registers cleared.
  - Reset asserted mid-sequence aborts any pending beat; no partial write occurs afterwards.
- States: IDLE, WR_LO, WR_HI.
- IDLE: in_ready=1.
  - On in_valid, capture lo, hi, addresses, long_op and reg_write on the clock edge.
    - lo = long_op ? Result2 : Result.
    - hi = Result.
  - ALUOut <= lo.
  - Next state: WR_LO if reg_write, else stay in IDLE and pulse done next cycle.
- Flag update on the capture edge:
  - FlagWrite[1] and !long_op: N,Z <= ALUFlags[3:2].
  - FlagWrite[1] and long_op: N <= hi[31]; Z <= ({hi,lo}==0), i.e. a 64-bit zero test.
  - FlagWrite[0] and !long_op: C,V <= ALUFlags[1:0].
  - long_op: C,V are never modified.
- WR_LO: WE3=1, A3=rd_lo, WD3=lo.
  - Beat completes on a cycle with wb_ready=1.
  - long_op: go to WR_HI.
  - Otherwise: go to IDLE and pulse done.
  - wb_ready=0: hold WE3/A3/WD3 stable and stay in WR_LO.
- WR_HI: WE3=1, A3=rd_hi, WD3=hi.
  - Completes on wb_ready=1; then go to IDLE and pulse done.
  - Stalls exactly as in WR_LO.
- Write outputs are registered. When no beat is active, WE3=0 and A3/WD3 hold their last values.
- Latency (wb_ready held high, capture edge = cycle 0):
  - Normal op: write on cycle 1, done on cycle 2.
  - Long op: lo on cycle 1, hi on cycle 2, done on cycle 3.
- in_valid while busy (not IDLE) is ignored; the control FSM must observe in_ready.
- Long op with rd_lo==rd_hi: both beats are issued in order, so hi wins (deterministic).
- done and in_ready may be high in the same cycle; a new capture is legal then.

Optional Feature:
- ALU_WB_BYPASS_EN defined:
  - Applies in IDLE when in_valid, !long_op, reg_write and wb_ready are all high.
  - WE3/A3/WD3 are driven combinationally from rd_lo/Result in the same cycle.
  - Capture still occurs; the state stays IDLE and done pulses next cycle.
  - Normal-op write latency becomes 0.
- Undefined: all writes are registered as described above.

Decomposition:
- Shared package (arm_pkg):
  - state encoding typedef {IDLE, WR_LO, WR_HI}.
  - ALUControl constants ALU_UMULL=3'b110, ALU_SMULL=3'b111.
  - Flag bit-index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
- One natural sub-module, flag_reg: the 4-bit NZCV register with per-pair enables and the 64-bit Z computation.

Test Plan:
- ADD, reg_write=1, FlagWrite=11, Result=0x00000005, ALUFlags=0000, rd_lo=3:
  - Cycle 1: WE3=1, A3=3, WD3=5.
  - done on cycle 2; Flags=0000.
- UMULL, Result=0x00000001, Result2=0x80000000, rd_lo=4, rd_hi=5, FlagWrite=10, prior Flags=0011:
  - Writes R4=0x80000000, then R5=0x00000001.
  - Flags=0011 (N=0, Z=0, C,V untouched).
- SMULL with {Result,Result2}=0 and FlagWrite=10:
  - Z=1, N=0, even though the ALU's own 32-bit Z path is not used.
- Long op with wb_ready low for 3 cycles in WR_LO:
  - WE3/A3/WD3 stay stable.
  - Hi beat follows only after the lo beat completes.
  - done only after the hi beat.
- reset driven low during WR_HI:
  - All outputs go to 0 immediately.
  - After release, no WE3 until a new in_valid.
- CMP-style op (reg_write=0, FlagWrite=11, ALUFlags=0110):
  - No WE3.
  - Flags=0110 after the capture edge; done next cycle.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM multicycle datapath: write-back FSM states,
// long-multiply ALU controls and NZCV bit positions.
package arm_pkg;

  localparam int unsigned FLAG_W = 4;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  localparam logic [2:0] ALU_UMULL = 3'b110;
  localparam logic [2:0] ALU_SMULL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_e;

  // True for the ALU controls that produce a 64-bit product in two words.
  function automatic logic is_long_op(input logic [2:0] alu_control);
    return (alu_control == ALU_UMULL) || (alu_control == ALU_SMULL);
  endfunction

endpackage

// File: rtl/alu_wb_seq_if.sv
// ALU-result issue channel and register-file write port seen by alu_wb_seq.
interface alu_wb_seq_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] Result;
  logic [DATA_W-1:0] Result2;
  logic [3:0]        ALUFlags;
  logic              long_op;
  logic              reg_write;
  logic [1:0]        FlagWrite;
  logic [ADDR_W-1:0] rd_lo;
  logic [ADDR_W-1:0] rd_hi;

  logic              wb_ready;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;

  modport master (
    output in_valid, Result, Result2, ALUFlags, long_op, reg_write,
           FlagWrite, rd_lo, rd_hi, wb_ready,
    input  in_ready, WE3, A3, WD3
  );

  modport slave (
    input  in_valid, Result, Result2, ALUFlags, long_op, reg_write,
           FlagWrite, rd_lo, rd_hi, wb_ready,
    output in_ready, WE3, A3, WD3
  );

endinterface

// File: rtl/flag_reg.sv
// Architectural NZCV register; N/Z come from a 64-bit product for long multiplies.
module flag_reg
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nz_en,
  input  logic              cv_en,
  input  logic              long_op,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  output logic [FLAG_W-1:0] flags
);

  logic n_c;
  logic z_c;

  // The ALU only sees 32 bits, so long-op N/Z are derived from the full product.
  always_comb begin
    n_c = alu_flags[N_IDX];
    z_c = alu_flags[Z_IDX];
    if (long_op) begin
      n_c = hi[DATA_W-1];
      z_c = ({hi, lo} == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else begin
      if (nz_en) begin
        flags[N_IDX] <= n_c;
        flags[Z_IDX] <= z_c;
      end
      if (cv_en && !long_op) begin
        flags[C_IDX] <= alu_flags[C_IDX];
        flags[V_IDX] <= alu_flags[V_IDX];
      end
    end
  end

endmodule

// File: rtl/alu_wb_seq.sv
// ALU write-back sequencer: captures ALU results/flags and issues one or two
// register-file write beats. Optional macro ALU_WB_BYPASS_EN enables 0-latency normal writes.
module alu_wb_seq
  import arm_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_wb_seq_if.slave       bus,
  output logic [DATA_W-1:0] ALUOut,
  output logic [FLAG_W-1:0] Flags,
  output logic              done
);

  wb_state_e state_q;
  wb_state_e state_d;

  logic              in_ready_q;
  logic              in_ready_d;
  logic              we3_q;
  logic              we3_d;
  logic [ADDR_W-1:0] a3_q;
  logic [ADDR_W-1:0] a3_d;
  logic [DATA_W-1:0] wd3_q;
  logic [DATA_W-1:0] wd3_d;
  logic              done_d;

  logic [DATA_W-1:0] hi_q;
  logic [ADDR_W-1:0] rd_hi_q;
  logic              long_q;

  logic              accept_c;
  logic              bypass_c;
  logic [DATA_W-1:0] cap_lo_c;

  assign accept_c = bus.in_valid && in_ready_q;
  assign cap_lo_c = bus.long_op ? bus.Result2 : bus.Result;

`ifdef ALU_WB_BYPASS_EN
  assign bypass_c = accept_c && !bus.long_op && bus.reg_write && bus.wb_ready;
`else
  assign bypass_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c && bus.reg_write && !bypass_c) begin
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        if (bus.wb_ready) begin
          state_d = long_q ? WR_HI : IDLE;
        end
      end
      WR_HI: begin
        if (bus.wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered write port, done and in_ready.
  always_comb begin
    we3_d      = we3_q;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    done_d     = 1'b0;
    in_ready_d = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        we3_d = 1'b0;
        if (accept_c) begin
          if (bus.reg_write) begin
            a3_d  = bus.rd_lo;
            wd3_d = cap_lo_c;
            if (bypass_c) begin
              done_d = 1'b1;
            end else begin
              we3_d = 1'b1;
            end
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WR_LO: begin
        if (bus.wb_ready) begin
          if (long_q) begin
            a3_d  = rd_hi_q;
            wd3_d = hi_q;
          end else begin
            we3_d  = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      WR_HI: begin
        if (bus.wb_ready) begin
          we3_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      default: we3_d = 1'b0;
    endcase
  end

  // Output and capture registers; reset drops any pending beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q <= 1'b0;
      we3_q      <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
      done       <= 1'b0;
      ALUOut     <= '0;
      hi_q       <= '0;
      rd_hi_q    <= '0;
      long_q     <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      we3_q      <= we3_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
      done       <= done_d;
      if (accept_c) begin
        ALUOut  <= cap_lo_c;
        hi_q    <= bus.Result;
        rd_hi_q <= bus.rd_hi;
        long_q  <= bus.long_op;
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.WE3      = we3_q || bypass_c;
  assign bus.A3       = bypass_c ? bus.rd_lo  : a3_q;
  assign bus.WD3      = bypass_c ? bus.Result : wd3_q;

  flag_reg #(
    .DATA_W (DATA_W)
  ) u_flag_reg (
    .clk       (clk),
    .reset     (reset),
    .nz_en     (accept_c && bus.FlagWrite[1]),
    .cv_en     (accept_c && bus.FlagWrite[0]),
    .long_op   (bus.long_op),
    .alu_flags (bus.ALUFlags),
    .hi        (bus.Result),
    .lo        (cap_lo_c),
    .flags     (Flags)
  );

endmodule

// File: tb/tb_alu_wb_seq.sv
// Directed self-checking bench for alu_wb_seq (default build, registered writes).
module tb_alu_wb_seq;
  import arm_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] alu_out;
  logic [3:0]        flags;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_wb_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  alu_wb_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .reset  (rst_n),
    .bus    (bus),
    .ALUOut (alu_out),
    .Flags  (flags),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] a, input logic [31:0] d);
    chk({tag, ".WE3"}, 64'(bus.WE3), 64'(we));
    chk({tag, ".A3"},  64'(bus.A3),  64'(a));
    chk({tag, ".WD3"}, 64'(bus.WD3), 64'(d));
  endtask

  // Present one op for a single capture edge, then drop in_valid.
  task automatic issue(input logic [2:0] ctl, input logic [31:0] res, input logic [31:0] res2,
                       input logic [3:0] af, input logic [1:0] fw, input logic rw,
                       input logic [3:0] rdl, input logic [3:0] rdh);
    bus.in_valid  = 1'b1;
    bus.long_op   = is_long_op(ctl);
    bus.Result    = res;
    bus.Result2   = res2;
    bus.ALUFlags  = af;
    bus.FlagWrite = fw;
    bus.reg_write = rw;
    bus.rd_lo     = rdl;
    bus.rd_hi     = rdh;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.long_op   = 1'b0;
    bus.Result    = '0;
    bus.Result2   = '0;
    bus.ALUFlags  = '0;
    bus.FlagWrite = '0;
    bus.reg_write = 1'b0;
    bus.rd_lo     = '0;
    bus.rd_hi     = '0;
    bus.wb_ready  = 1'b1;

    // Reset values while asserted.
    #12;
    chk_wr("rst", 1'b0, 4'h0, 32'h0);
    chk("rst.ALUOut", 64'(alu_out), 64'h0);
    chk("rst.Flags", 64'(flags), 64'h0);
    chk("rst.done", 64'(done), 64'h0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.in_ready", 64'(bus.in_ready), 64'h1);

    // ADD r3 = 5: write on cycle 1, done on cycle 2.
    issue(3'b000, 32'h5, 32'hDEAD, 4'b0000, 2'b11, 1'b1, 4'd3, 4'd0);
    chk_wr("add.c1", 1'b1, 4'd3, 32'h5);
    chk("add.c1.done", 64'(done), 64'h0);
    chk("add.c1.in_ready", 64'(bus.in_ready), 64'h0);
    chk("add.ALUOut", 64'(alu_out), 64'h5);
    @(negedge clk);
    chk_wr("add.c2", 1'b0, 4'd3, 32'h5);
    chk("add.c2.done", 64'(done), 64'h1);
    chk("add.Flags", 64'(flags), 64'h0);
    chk("add.c2.in_ready", 64'(bus.in_ready), 64'h1);

    // Flag-only op seeds C,V = 11.
    issue(3'b000, 32'h0, 32'h0, 4'b0011, 2'b11, 1'b0, 4'd0, 4'd0);
    chk("seed.Flags", 64'(flags), 64'h3);
    chk("seed.done", 64'(done), 64'h1);
    chk("seed.WE3", 64'(bus.WE3), 64'h0);
    @(negedge clk);
    chk("seed.done_drop", 64'(done), 64'h0);

    // UMULL R4,R5: lo=0x80000000 then hi=1; N/Z from 64-bit product, C,V kept.
    issue(ALU_UMULL, 32'h1, 32'h8000_0000, 4'b1111, 2'b10, 1'b1, 4'd4, 4'd5);
    chk_wr("umull.c1", 1'b1, 4'd4, 32'h8000_0000);
    chk("umull.ALUOut", 64'(alu_out), 64'h8000_0000);
    chk("umull.Flags", 64'(flags), 64'h3);
    @(negedge clk);
    chk_wr("umull.c2", 1'b1, 4'd5, 32'h1);
    chk("umull.c2.done", 64'(done), 64'h0);
    @(negedge clk);
    chk_wr("umull.c3", 1'b0, 4'd5, 32'h1);
    chk("umull.c3.done", 64'(done), 64'h1);

    // SMULL zero product: Z=1, N=0 despite ALU flags 1000; C,V untouched even with FlagWrite[0].
    issue(ALU_SMULL, 32'h0, 32'h0, 4'b1000, 2'b11, 1'b1, 4'd6, 4'd7);
    chk("smull.Flags", 64'(flags), 64'h7);
    chk_wr("smull.c1", 1'b1, 4'd6, 32'h0);
    @(negedge clk);
    chk_wr("smull.c2", 1'b1, 4'd7, 32'h0);
    @(negedge clk);
    chk("smull.done", 64'(done), 64'h1);

    // Long op stalled 3 cycles in WR_LO.
    bus.wb_ready = 1'b0;
    issue(ALU_UMULL, 32'hFFFF_0000, 32'h0000_1234, 4'b0000, 2'b10, 1'b1, 4'd8, 4'd9);
    chk("stall.Flags", 64'(flags), 64'hB);
    for (int i = 0; i < 3; i++) begin
      chk_wr($sformatf("stall.lo%0d", i), 1'b1, 4'd8, 32'h0000_1234);
      chk($sformatf("stall.done%0d", i), 64'(done), 64'h0);
      if (i < 2) @(negedge clk);
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    chk_wr("stall.hi", 1'b1, 4'd9, 32'hFFFF_0000);
    chk("stall.hi.done", 64'(done), 64'h0);
    @(negedge clk);
    chk("stall.done", 64'(done), 64'h1);
    chk("stall.WE3_off", 64'(bus.WE3), 64'h0);

    // Reset asserted during WR_HI aborts the sequence.
    issue(ALU_UMULL, 32'hAAAA_5555, 32'h5555_AAAA, 4'b0000, 2'b00, 1'b1, 4'd1, 4'd2);
    @(negedge clk);
    chk_wr("abort.hi", 1'b1, 4'd2, 32'hAAAA_5555);
    #2 rst_n = 1'b0;
    #1;
    chk_wr("abort.rst", 1'b0, 4'd0, 32'h0);
    chk("abort.ALUOut", 64'(alu_out), 64'h0);
    chk("abort.Flags", 64'(flags), 64'h0);
    chk("abort.in_ready", 64'(bus.in_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort.quiet%0d", i), 64'({bus.WE3, done}), 64'h0);
    end

    // CMP-style: flags only, no write, done next cycle.
    issue(3'b010, 32'h0, 32'h0, 4'b0110, 2'b11, 1'b0, 4'd3, 4'd0);
    chk("cmp.WE3", 64'(bus.WE3), 64'h0);
    chk("cmp.Flags", 64'(flags), 64'h6);
    chk("cmp.done", 64'(done), 64'h1);
    @(negedge clk);
    chk("cmp.done_drop", 64'(done), 64'h0);

    // rd_lo == rd_hi: both beats in order, hi last.
    issue(ALU_SMULL, 32'h22, 32'h11, 4'b0000, 2'b00, 1'b1, 4'd11, 4'd11);
    chk_wr("same.lo", 1'b1, 4'd11, 32'h11);
    @(negedge clk);
    chk_wr("same.hi", 1'b1, 4'd11, 32'h22);
    @(negedge clk);

    // in_valid while busy is ignored.
    issue(3'b000, 32'h77, 32'h0, 4'b0000, 2'b00, 1'b1, 4'd12, 4'd0);
    bus.in_valid  = 1'b1;
    bus.Result    = 32'h99;
    bus.rd_lo     = 4'd13;
    bus.ALUFlags  = 4'b1001;
    bus.FlagWrite = 2'b11;
    chk_wr("busy.c1", 1'b1, 4'd12, 32'h77);
    @(negedge clk);
    chk("busy.ALUOut", 64'(alu_out), 64'h77);
    chk("busy.Flags", 64'(flags), 64'h6);
    chk("busy.done", 64'(done), 64'h1);
    chk("busy.WE3", 64'(bus.WE3), 64'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
